// File: rtl/pwm_seq_pkg.sv
// Shared state encoding and default widths for the PWM pattern-ROM sequencer.
package pwm_seq_pkg;

  localparam int unsigned ADDR_W_DEFAULT = 8;
  localparam int unsigned DATA_W_DEFAULT = 8;
  localparam int unsigned DIV_W_DEFAULT  = 16;

  typedef enum logic [1:0] {
    StIdle     = 2'd0,
    StRun      = 2'd1,
    StStopping = 2'd2
  } seq_state_e;

endpackage

// File: rtl/seq_prescaler.sv
// Step-rate prescaler: counts 0..limit and pulses tick on the terminal count.
module seq_prescaler #(
  parameter int unsigned DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic [DIV_W-1:0] limit,
  output logic             tick
);

  logic [DIV_W-1:0] cnt_q, cnt_d;

  assign tick = !clr && (cnt_q == limit);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/pwm_rom_sequencer.sv
// Steps the three-phase PWM pattern ROM and registers its outputs as phase drives.
// Reverse stepping and the dir port are built only when PWM_SEQ_REVERSE_EN is defined.
module pwm_rom_sequencer
  import pwm_seq_pkg::*;
#(
  parameter int unsigned ADDR_W = ADDR_W_DEFAULT,
  parameter int unsigned DATA_W = DATA_W_DEFAULT,
  parameter int unsigned DIV_W  = DIV_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              stop,
  input  logic [DIV_W-1:0]  div,
`ifdef PWM_SEQ_REVERSE_EN
  input  logic              dir,
`endif
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [DATA_W-1:0] rom_out1,
  input  logic [DATA_W-1:0] rom_out2,
  input  logic [DATA_W-1:0] rom_out3,
  output logic [DATA_W-1:0] pwm1,
  output logic [DATA_W-1:0] pwm2,
  output logic [DATA_W-1:0] pwm3,
  output logic              busy,
  output logic              sync
);

  seq_state_e        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d, step_addr;
  logic [DIV_W-1:0]  div_q;
  logic [DATA_W-1:0] pwm1_q, pwm2_q, pwm3_q;
  logic              sync_q;
  logic              tick, wrap, launch, running;

  assign running = (state_q != StIdle);
  assign launch  = (state_q == StIdle) && start;

`ifdef PWM_SEQ_REVERSE_EN
  logic dir_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                 dir_q <= 1'b0;
    else if (launch || wrap) dir_q <= dir;
  end

  assign step_addr = dir_q ? addr_q - 1'b1 : addr_q + 1'b1;
`else
  assign step_addr = addr_q + 1'b1;
`endif

  // Every period boundary is a step into address 0, in either direction.
  assign wrap = tick && (step_addr == '0);

  seq_prescaler #(
    .DIV_W (DIV_W)
  ) u_prescaler (
    .clk   (clk),
    .rst   (rst),
    .clr   (!running),
    .limit (div_q),
    .tick  (tick)
  );

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    unique case (state_q)
      StIdle: begin
        addr_d = '0;
        if (start) state_d = StRun;
      end
      StRun:      if (stop) state_d = StStopping;
      StStopping: begin
        if (start)     state_d = StRun;
        else if (wrap) state_d = StIdle;
      end
      default:    state_d = StIdle;
    endcase
    if (running && tick) addr_d = step_addr;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
      div_q   <= '0;
      sync_q  <= 1'b0;
      pwm1_q  <= '0;
      pwm2_q  <= '0;
      pwm3_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      sync_q  <= wrap;
      if (launch || wrap) div_q <= div;
      // Drives follow the ROM only while running; the edge into idle forces switches off.
      if (running && (state_d != StIdle)) begin
        pwm1_q <= rom_out1;
        pwm2_q <= rom_out2;
        pwm3_q <= rom_out3;
      end else begin
        pwm1_q <= '0;
        pwm2_q <= '0;
        pwm3_q <= '0;
      end
    end
  end

  assign rom_addr = addr_q;
  assign pwm1     = pwm1_q;
  assign pwm2     = pwm2_q;
  assign pwm3     = pwm3_q;
  assign busy     = running;
  assign sync     = sync_q;

endmodule

// File: tb/tb_pwm_rom_sequencer.sv
// Self-checking bench for pwm_rom_sequencer: period-position model plus directed checks.
module tb_pwm_rom_sequencer;

  logic        clk = 1'b0;
  logic        rst, start, stop, dir;
  logic [15:0] div;
  logic [7:0]  rom_addr, rom_out1, rom_out2, rom_out3, pwm1, pwm2, pwm3;
  logic        busy, sync;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  function automatic logic [7:0] rom_f(input int ph, input logic [7:0] a);
    case (ph)
      1:       return a ^ 8'h5A;
      2:       return a + 8'd85;
      default: return ~a;
    endcase
  endfunction

  assign rom_out1 = rom_f(1, rom_addr);
  assign rom_out2 = rom_f(2, rom_addr);
  assign rom_out3 = rom_f(3, rom_addr);

  pwm_rom_sequencer dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .div      (div),
`ifdef PWM_SEQ_REVERSE_EN
    .dir      (dir),
`endif
    .rom_addr (rom_addr),
    .rom_out1 (rom_out1),
    .rom_out2 (rom_out2),
    .rom_out3 (rom_out3),
    .pwm1     (pwm1),
    .pwm2     (pwm2),
    .pwm3     (pwm3),
    .busy     (busy),
    .sync     (sync)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Model: position within the period is elapsed clocks / (div+1); mode 0 idle, 1 run, 2 stopping.
  int         m_mode, m_t, m_div, m_dir, m_addr;
  logic [7:0] m_pwm1, m_pwm2, m_pwm3;
  logic       m_sync;

  always @(posedge clk or posedge rst) begin : model
    int k;
    bit boundary;
    if (rst) begin
      m_mode = 0; m_t = 0; m_div = 0; m_dir = 0; m_addr = 0;
      m_pwm1 = 0; m_pwm2 = 0; m_pwm3 = 0; m_sync = 0;
    end else begin
      m_sync = 0;
      if (m_mode == 0) begin
        m_pwm1 = 0; m_pwm2 = 0; m_pwm3 = 0;
        if (start) begin
          m_mode = 1; m_t = 0; m_div = int'(div); m_dir = int'(dir); m_addr = 0;
        end
      end else begin
        m_pwm1 = rom_f(1, 8'(m_addr));
        m_pwm2 = rom_f(2, 8'(m_addr));
        m_pwm3 = rom_f(3, 8'(m_addr));
        m_t++;
        k = m_t / (m_div + 1);
        boundary = (k == 256);
        if (boundary) begin
          m_t = 0; m_sync = 1; m_div = int'(div); m_dir = int'(dir); m_addr = 0;
        end else begin
          m_addr = (m_dir != 0) ? (256 - k) % 256 : k;
        end
        if (m_mode == 1) begin
          if (stop) m_mode = 2;
        end else if (start) begin
          m_mode = 1;
        end else if (boundary) begin
          m_mode = 0; m_pwm1 = 0; m_pwm2 = 0; m_pwm3 = 0;
        end
      end
    end
  end

  always @(negedge clk) begin
    check("rom_addr", 32'(rom_addr), 32'(m_addr[7:0]));
    check("pwm1", 32'(pwm1), 32'(m_pwm1));
    check("pwm2", 32'(pwm2), 32'(m_pwm2));
    check("pwm3", 32'(pwm3), 32'(m_pwm3));
    check("busy", 32'(busy), 32'(m_mode != 0));
    check("sync", 32'(sync), 32'(m_sync));
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sync(input int bound, output int n);
    n = 0;
    do begin tick(); n++; end while (sync !== 1'b1 && n < bound);
    if (sync !== 1'b1) check("sync timeout", 0, 1);
  endtask

  task automatic wait_addr(input logic [7:0] a, input int bound);
    int n = 0;
    do begin tick(); n++; end while (rom_addr !== a && n < bound);
    if (rom_addr !== a) check("addr timeout", 32'(rom_addr), 32'(a));
  endtask

  task automatic wait_idle(input int bound);
    int n = 0;
    do begin tick(); n++; end while (busy !== 1'b0 && n < bound);
    if (busy !== 1'b0) check("idle timeout", 32'(busy), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete, checks %0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    rst = 1'b1; start = 1'b0; stop = 1'b0; div = 16'd0; dir = 1'b0;
    repeat (3) tick();
    check("reset addr", 32'(rom_addr), 0);
    check("reset busy", 32'(busy), 0);
    rst = 1'b0;
    tick();

    // Forward sweep, div 0.
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start busy", 32'(busy), 1);
    check("start addr", 32'(rom_addr), 0);
    tick();
    check("first step addr", 32'(rom_addr), 1);
    check("first pwm1", 32'(pwm1), 32'h5A);
    wait_sync(600, n);
    check("first period", 32'(n), 255);
    div = 16'd3;
    wait_sync(600, n);
    check("period div0", 32'(n), 256);

    // Prescaler: div 3 takes effect here; mid-period change to 1 waits for the boundary.
    wait_sync(2000, n);
    check("period div3", 32'(n), 1024);
    repeat (100) tick();
    div = 16'd1;
    wait_sync(2000, n);
    check("period div3 after change", 32'(n), 924);
    wait_sync(2000, n);
    check("period div1", 32'(n), 512);

    // Clean stop at 0x80.
    wait_addr(8'h80, 600);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    check("stopping busy", 32'(busy), 1);
    wait_idle(600);
    check("stop addr", 32'(rom_addr), 0);
    check("stop pwm1", 32'(pwm1), 0);
    check("stop pwm3", 32'(pwm3), 0);
    check("stop sync", 32'(sync), 1);

    // Stop cancelled by start at 0xC0.
    div = 16'd0;
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_addr(8'h80, 300);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_addr(8'hC0, 300);
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_sync(300, n);
    check("cancel keeps run", 32'(busy), 1);

    // Simultaneous start/stop: from RUN stop wins; from IDLE start wins.
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    wait_idle(300);
    start = 1'b1; stop = 1'b1;
    tick();
    check("both in idle -> run", 32'(busy), 1);
    tick();
    start = 1'b0; stop = 1'b0;
    wait_idle(300);
    check("both in run -> stop", 32'(rom_addr), 0);

    // Asynchronous reset mid-run at 0x37.
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_addr(8'h37, 300);
    check("pre-reset pwm1", 32'(pwm1), 32'(8'h36 ^ 8'h5A));
    #2 rst = 1'b1;
    #1;
    check("async reset addr", 32'(rom_addr), 0);
    check("async reset pwm2", 32'(pwm2), 0);
    check("async reset busy", 32'(busy), 0);
    tick();
    rst = 1'b0;
    tick();

`ifdef PWM_SEQ_REVERSE_EN
    dir = 1'b1;
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    check("reverse first", 32'(rom_addr), 32'hFF);
    repeat (50) tick();
    check("reverse k51", 32'(rom_addr), 32'hCD);
    dir = 1'b0;
    wait_sync(300, n);
    check("reverse period rest", 32'(n), 205);
    tick();
    check("forward after boundary", 32'(rom_addr), 1);
    stop = 1'b1;
    tick();
    stop = 1'b0;
    wait_idle(300);
`endif

    repeat (3) tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pwm_rom_sequencer.md
# pwm_rom_sequencer

Address sequencer and output register stage for the three-phase PWM pattern ROM (256 × 3 × 8-bit, asynchronous read). It steps the ROM address at a programmable rate, re-registers the three ROM outputs as the phase drive buses, and handles run/stop control so that switching starts and stops cleanly on a pattern-period boundary. It sits between the control registers and the gate-drive logic and replaces free-running address counting.

## Interface
- `ADDR_W`, 8: ROM address width; the pattern period is 2^ADDR_W steps.
- `DATA_W`, 8: width of each ROM phase output.
- `DIV_W`, 16: prescaler width.

Ports:
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: asynchronous, active-high reset.
- `start` in 1: level-sampled run request.
- `stop` in 1: level-sampled stop request.
- `div` in DIV_W: clocks per ROM step minus 1.
- `dir` in 1: 0 = forward, 1 = reverse. Present only with `PWM_SEQ_REVERSE_EN`.
- `rom_addr` out ADDR_W: address to the ROM.
- `rom_out1`, `rom_out2`, `rom_out3` in DATA_W: ROM data, valid in the same cycle as the address.
- `pwm1`, `pwm2`, `pwm3` out DATA_W: registered phase drive buses.
- `busy` out 1: high when the state is not IDLE.
- `sync` out 1: one-cycle pulse on each step into address 0.

## Operation
- **States:** IDLE, RUN, STOPPING.
- **IDLE:**
  - `start`=1 moves to RUN. `stop` is ignored.
  - On entry to RUN: `div` is latched into `div_q`, `dir` is latched into `dir_q`, the prescaler clears, and `rom_addr` is 0.
- **RUN:**
  - `stop`=1 moves to STOPPING. `start` is ignored.
  - If `start` and `stop` are both high in RUN, `stop` wins.
- **STOPPING:**
  - Stepping continues.
  - `start`=1 returns to RUN (cancels the stop) without touching the address or prescaler.
  - On the step into address 0, the block goes to IDLE.
- **Prescaler:**
  - Counts 0..`div_q`. A tick is issued when count equals `div_q`; the count then wraps to 0.
  - `div_q`=0 gives a tick every cycle.
- **Step on tick:**
  - Forward: `rom_addr`+1, modulo 2^ADDR_W.
  - Reverse: `rom_addr`−1, modulo 2^ADDR_W (0→255→…→1→0).
- **Period boundary:** on a step into 0, `sync`=1 for one cycle, and `div_q` and `dir_q` are re-latched from the inputs. Changes to `div` and `dir` mid-period therefore take effect only at the boundary.
- **Output stage:**
  - While the state is RUN or STOPPING, every cycle: `pwmk` <= `rom_outk`.
  - On the edge entering IDLE, all `pwmk` <= 0, which forces all switches off.

## Timing
- **Reset values:** `rom_addr`=0, `pwm1..3`=0, `busy`=0, `sync`=0, state IDLE, prescaler 0, `div_q`=0, `dir_q`=0.
- **Start:** `start` high at edge N gives `busy`=1 after edge N. `pwmk` = ROM[0] after edge N+1.
- **First step:** `rom_addr` first changes after edge N+1+`div_q`.
- **Latency:** `pwmk` lags `rom_addr` by exactly 1 clock.
- **Full period:** `sync` pulses every 2^ADDR_W × (`div_q`+1) clocks.
- **Stop:** on the edge where `rom_addr` becomes 0 in STOPPING:
  - state becomes IDLE and `busy`=0;
  - `pwmk`=0;
  - `sync`=1 for that one cycle.
- **Reset mid-operation:** asynchronous return to the reset values. There is no drain.

## Configuration
- **`PWM_SEQ_REVERSE_EN` defined:** `dir` port exists, and reverse stepping is supported (phase-sequence reversal).
- **Undefined:**
  - `dir` port is absent;
  - `dir_q` is tied to 0;
  - only the forward incrementer is built.

## Structure
- **Package `pwm_seq_pkg`:** state encoding (IDLE/RUN/STOPPING) and default width constants for ADDR_W, DATA_W and DIV_W.
- **Sub-module `seq_prescaler`:** a DIV_W counter with clear input, `div_q` compare and one-cycle `tick` output. All other logic lives in the top module.

## Test plan
- **Reset:** assert `rst` mid-run with `rom_addr`=0x37 → all outputs 0 immediately; IDLE; `busy`=0.
- **Full forward sweep:** `div`=0, `start` pulse → `rom_addr` steps 0→255→0 in 256 clocks; `sync` pulses every 256 clocks; `pwmk` = ROM[addr−1] each cycle.
- **Prescaler:** `div`=3 → each address held 4 clocks; `sync` period 1024 clocks. Change `div` to 1 mid-period → new rate only after the next `sync`.
- **Clean stop:** `stop` at `rom_addr`=0x80 → stepping continues through 0xFF; IDLE on the step into 0; `pwm1..3`=0 on that edge. Re-asserting `start` at 0xC0 instead cancels the stop and keeps RUN.
- **Simultaneous requests:** `start` and `stop` high together in IDLE → RUN. The same pair in RUN → STOPPING.
- **Reverse (`PWM_SEQ_REVERSE_EN`):** `dir`=1 at start → `rom_addr` 0→255→254…→1→0; `sync` on each step into 0. Toggling `dir` mid-period has no effect until the boundary.
